apb4_wdg_feeder: RTL and testbench

APB4 initiator that services the APB4 watchdog: on a periodic tick or a software request it issues the unlock-and-feed write sequence (KEY, FEED=1, KEY, FEED=0) over an APB4 master port. It sits between a subsystem that must keep the watchdog alive (boot ROM sequencer, safety monitor) and the APB4 interconnect leading to the watchdog slave.

---
 rtl/wdg_feeder_pkg.sv | 54 +++++
 rtl/wdg_feed_tmr.sv | 48 ++++
 rtl/apb4_wdg_feeder.sv | 174 +++++++++++++++++
 tb/tb_apb4_wdg_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdg_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wdg_feeder_pkg
// Purpose  : Shared constants and types for the APB4 watchdog feeder.
//            Holds the watchdog register byte offsets, the unlock key, the
//            APB FSM state encoding and the per-step transfer decode.
// Options  : WDG_FEEDER_STAT_CHK_EN adds a fifth step (STAT read).
// Revision : 1.0 - initial release
// ============================================================================
package wdg_feeder_pkg;

    localparam logic [31:0] c_OFS_STAT  = 32'h0000_0010;
    localparam logic [31:0] c_OFS_KEY   = 32'h0000_0014;
    localparam logic [31:0] c_OFS_FEED  = 32'h0000_0018;
    localparam logic [31:0] c_KEY_VALUE = 32'h5F37_59DF;

`ifdef WDG_FEEDER_STAT_CHK_EN
    localparam int unsigned c_STEP_CNT = 5;
`else
    localparam int unsigned c_STEP_CNT = 4;
`endif

    localparam int unsigned c_STEP_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] ofs;
        logic [31:0] data;
        logic        write;
    } step_t;

    // KEY precedes each FEED write: the slave drops its unlock on any
    // other write, so every protected write needs a fresh KEY.
    function automatic step_t step_decode(input logic [c_STEP_W-1:0] step);
        step_t s;
        s = '0;
        case (step)
            3'd0: s = '{ofs: c_OFS_KEY,  data: c_KEY_VALUE,  write: 1'b1};
            3'd1: s = '{ofs: c_OFS_FEED, data: 32'd1,        write: 1'b1};
            3'd2: s = '{ofs: c_OFS_KEY,  data: c_KEY_VALUE,  write: 1'b1};
            3'd3: s = '{ofs: c_OFS_FEED, data: 32'd0,        write: 1'b1};
            3'd4: s = '{ofs: c_OFS_STAT, data: 32'd0,        write: 1'b0};
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wdg_feed_tmr.sv
`default_nettype none
// ============================================================================
// Module   : wdg_feed_tmr
// Purpose  : Feed-period counter. Counts pclk cycles while enabled with a
//            non-zero period and emits a one-cycle tick on wrap.
// Ports    : pclk, presetn (async active-low), en_i, period_i -> tick_o
// Revision : 1.0 - initial release
// ============================================================================
module wdg_feed_tmr #(
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    en_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    tick_o
);

    logic [PERIOD_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0] count_d;
    logic                    w_tick;

    // The >= compare lets a shortened period take effect at once instead
    // of waiting for the counter to wrap through the full width.
    always_comb begin
        count_d = '0;
        w_tick  = 1'b0;
        if (en_i && (period_i != '0)) begin
            if (count_q >= (period_i - 1'b1)) begin
                w_tick = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = w_tick;

endmodule
`default_nettype wire

// File: rtl/apb4_wdg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : apb4_wdg_feeder
// Purpose  : APB4 initiator that feeds the APB4 watchdog. A periodic tick or
//            a software request triggers KEY, FEED=1, KEY, FEED=0 writes.
// Ports    : pclk/presetn (async active-low); en_i, period_i, feed_req_i,
//            err_clr_i control; APB4 master p*_o / p*_i; busy_o, done_o,
//            err_o status (+ ovif_o when the STAT check is compiled in).
// Options  : WDG_FEEDER_STAT_CHK_EN - adds a STAT read step; prdata_i[0]=1
//            on that read sets sticky ovif_o.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_wdg_feeder
    import wdg_feeder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    en_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    feed_req_i,
    input  logic                    err_clr_i,
    output logic [31:0]             paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [31:0]             pwdata_o,
    output logic [3:0]              pstrb_o,
    input  logic [31:0]             prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
`ifdef WDG_FEEDER_STAT_CHK_EN
    ,
    output logic                    ovif_o
`endif
);

    state_e              state_q, state_d;
    logic [c_STEP_W-1:0] step_q, step_d;
    logic                pending_q, pending_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                w_tick;
    logic                w_req;
    logic                w_busy;
    logic                w_err_set;
    step_t               w_step;

    wdg_feed_tmr #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_tmr (
        .pclk     (pclk),
        .presetn  (presetn),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (w_tick)
    );

    // Ticks and requests coalesce into one pending feed.
    assign w_req  = pending_q | w_tick | feed_req_i;
    assign w_busy = (state_q != ST_IDLE);
    assign w_step = step_decode(step_q);

`ifdef WDG_FEEDER_STAT_CHK_EN
    logic ovif_q, ovif_d;
    logic w_ovif_set;
`else
    logic w_unused_prdata;
    assign w_unused_prdata = ^prdata_i;
`endif

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pending_d  = w_req;
        done_d     = 1'b0;
        w_err_set  = 1'b0;
`ifdef WDG_FEEDER_STAT_CHK_EN
        w_ovif_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    state_d   = ST_SETUP;
                    step_d    = '0;
                    pending_d = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        // Abandon the rest: a half-unlocked slave is
                        // safer than continuing after an error.
                        w_err_set = 1'b1;
                        state_d   = ST_IDLE;
                        step_d    = '0;
                    end else begin
`ifdef WDG_FEEDER_STAT_CHK_EN
                        w_ovif_set = !w_step.write && prdata_i[0];
`endif
                        if (step_q == c_STEP_W'(c_STEP_CNT - 1)) begin
                            state_d = ST_IDLE;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SETUP;
                            step_d  = step_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
        // A new error wins over a simultaneous clear.
        err_d = (err_q & ~err_clr_i) | w_err_set;
`ifdef WDG_FEEDER_STAT_CHK_EN
        ovif_d = (ovif_q & ~err_clr_i) | w_ovif_set;
`endif
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef WDG_FEEDER_STAT_CHK_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ovif_q <= 1'b0;
        end else begin
            ovif_q <= ovif_d;
        end
    end
    assign ovif_o = ovif_q;
`endif

    // Transfer attributes come straight from the step register, so they
    // stay stable from SETUP through the last ACCESS cycle.
    assign psel_o    = w_busy;
    assign penable_o = (state_q == ST_ACCESS);
    assign paddr_o   = w_busy ? (BASE_ADDR + w_step.ofs) : 32'd0;
    assign pwrite_o  = w_busy & w_step.write;
    assign pwdata_o  = (w_busy && w_step.write) ? w_step.data : 32'd0;
    assign pstrb_o   = (w_busy && w_step.write) ? 4'hF : 4'h0;
    assign pprot_o   = 3'b000;
    assign busy_o    = w_busy;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_wdg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_wdg_feeder
// Purpose  : Self-checking bench for apb4_wdg_feeder. Random stimulus is
//            compared cycle by cycle against a transaction-level model of
//            the feed sequence (beat table + wait-state age counter).
// Options  : WDG_FEEDER_STAT_CHK_EN - also checks the STAT beat and ovif_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_wdg_feeder;

    localparam logic [31:0] c_BASE = 32'h4000_1000;
`ifdef WDG_FEEDER_STAT_CHK_EN
    localparam int c_NBEATS = 5;
`else
    localparam int c_NBEATS = 4;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic        en;
    logic [31:0] period;
    logic        feed_req;
    logic        err_clr;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        busy, done, err;
`ifdef WDG_FEEDER_STAT_CHK_EN
    logic        ovif;
`endif

    always #5 pclk = ~pclk;

    apb4_wdg_feeder #(
        .BASE_ADDR    (c_BASE),
        .PERIOD_WIDTH (32)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .en_i       (en),
        .period_i   (period),
        .feed_req_i (feed_req),
        .err_clr_i  (err_clr),
        .paddr_o    (paddr),
        .pprot_o    (pprot),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
`ifdef WDG_FEEDER_STAT_CHK_EN
        ,
        .ovif_o     (ovif)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] beat_addr [5];
    logic [31:0] beat_data [5];
    bit          beat_wr   [5];

    int m_count, m_beat, m_age;
    bit m_pending, m_active, m_done, m_err, m_ovif;
    int hold_period;

    task automatic model_reset();
        m_count = 0; m_beat = 0; m_age = 0;
        m_pending = 0; m_active = 0; m_done = 0; m_err = 0; m_ovif = 0;
    endtask

    // One clock edge of the feeder, evaluated from the inputs held during
    // the cycle that just ended.
    task automatic model_step();
        bit tick, req, err_set, ov_set, done_n;
        tick = 0; err_set = 0; ov_set = 0; done_n = 0;
        if (en && period != 0) begin
            if (m_count >= int'(period) - 1) begin
                tick = 1; m_count = 0;
            end else begin
                m_count++;
            end
        end else begin
            m_count = 0;
        end
        req = m_pending || tick || feed_req;
        if (!m_active) begin
            if (req) begin
                m_active = 1; m_beat = 0; m_age = 0;
            end
            m_pending = 0;
        end else begin
            m_pending = req;
            if (m_age == 0) begin
                m_age = 1;
            end else if (pready) begin
                if (pslverr) begin
                    err_set = 1; m_active = 0;
                end else begin
                    if (!beat_wr[m_beat] && prdata[0]) ov_set = 1;
                    if (m_beat == c_NBEATS - 1) begin
                        m_active = 0; done_n = 1;
                    end else begin
                        m_beat++; m_age = 0;
                    end
                end
            end else begin
                m_age++;
            end
        end
        m_done = done_n;
        m_err  = (m_err && !err_clr) || err_set;
        m_ovif = (m_ovif && !err_clr) || ov_set;
    endtask

    task automatic check_outputs();
        logic [31:0] e_addr, e_data;
        logic        e_wr;
        e_addr = m_active ? beat_addr[m_beat] : 32'd0;
        e_wr   = m_active && beat_wr[m_beat];
        e_data = e_wr ? beat_data[m_beat] : 32'd0;
        check_val("psel",    32'(psel),    32'(m_active));
        check_val("penable", 32'(penable), 32'(m_active && m_age >= 1));
        check_val("paddr",   paddr,        e_addr);
        check_val("pwrite",  32'(pwrite),  32'(e_wr));
        check_val("pwdata",  pwdata,       e_data);
        check_val("pstrb",   32'(pstrb),   e_wr ? 32'hF : 32'h0);
        check_val("pprot",   32'(pprot),   32'h0);
        check_val("busy",    32'(busy),    32'(m_active));
        check_val("done",    32'(done),    32'(m_done));
        check_val("err",     32'(err),     32'(m_err));
`ifdef WDG_FEEDER_STAT_CHK_EN
        check_val("ovif",    32'(ovif),    32'(m_ovif));
`endif
    endtask

    // mode 0: software requests only, zero-wait slave
    // mode 1: period 20, zero-wait slave
    // mode 2: random periods, wait states, errors, clears
    // mode 3: en/period toggling including period 0 and 1
    task automatic drive_inputs(input int mode);
        case (mode)
            0: begin
                en = 0; period = 0; feed_req = ($urandom % 16) == 0;
                pready = 1; pslverr = 0; err_clr = 0; prdata = $urandom;
            end
            1: begin
                en = 1; period = 20; feed_req = 0;
                pready = 1; pslverr = 0; err_clr = 0; prdata = 0;
            end
            2: begin
                if (($urandom % 40) == 0) hold_period = $urandom_range(1, 12);
                en = 1; period = hold_period;
                feed_req = ($urandom % 8) == 0;
                pready   = ($urandom % 4) != 0;
                pslverr  = ($urandom % 16) == 0;
                err_clr  = ($urandom % 20) == 0;
                prdata   = $urandom;
            end
            default: begin
                en = ($urandom % 8) != 0;
                if (($urandom % 25) == 0) period = $urandom_range(0, 6);
                feed_req = ($urandom % 12) == 0;
                pready   = ($urandom % 3) != 0;
                pslverr  = ($urandom % 24) == 0;
                err_clr  = ($urandom % 30) == 0;
                prdata   = $urandom;
            end
        endcase
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            model_step();
            check_outputs();
            drive_inputs(mode);
        end
    endtask

    task automatic quiet_inputs();
        en = 0; period = 0; feed_req = 0; err_clr = 0;
        pready = 1; pslverr = 0; prdata = 0;
    endtask

    // Reset in the middle of an ACCESS beat: outputs must drop before the
    // next clock edge, and nothing resumes afterwards.
    task automatic reset_mid_sequence();
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge pclk);
            #1;
            model_step();
            check_outputs();
            if (m_active && m_age >= 1) got = 1;
            else drive_inputs(0);
        end
        check_val("rst_wait_active", 32'(got), 32'h1);
        presetn = 0;
        #1;
        model_reset();
        check_outputs();
        quiet_inputs();
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1;
    endtask

    initial begin
        beat_addr = '{c_BASE + 32'h14, c_BASE + 32'h18, c_BASE + 32'h14, c_BASE + 32'h18, c_BASE + 32'h10};
        beat_data = '{32'h5F37_59DF, 32'h1, 32'h5F37_59DF, 32'h0, 32'h0};
        beat_wr   = '{1, 1, 1, 1, 0};
        hold_period = 5;
        quiet_inputs();
        presetn = 1;
        #2 presetn = 0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_outputs();
        @(negedge pclk);
        presetn = 1;

        run(0, 300);
        run(1, 300);
        reset_mid_sequence();
        run(2, 1500);
        reset_mid_sequence();
        run(3, 1500);
        quiet_inputs();
        run(0, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
